// File: rtl/glitc_datapath_reader.sv
// Read-end controller for the GLITC datapath buffers: startup sequencing, valid
// monitoring and a single-channel capture RAM for register readout.
module glitc_datapath_reader #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 255,
    parameter int RST_CYCLES = 4
) (
    input  logic                  SYSCLK,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  fifo_rst_o,
    output logic                  en_o,
    input  logic                  valid_i,
    input  logic [287:0]          dat_i,
    input  logic                  capture_i,
    input  logic [2:0]            ch_sel_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [47:0]           rd_data_o,
    output logic                  running_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic                  err_o,
    output logic [1:0]            state_dbg_o
);

    // valid_i is a level acknowledge, not a handshake: the buffers hold it high
    // for as long as dat_i carries a fresh sample every SYSCLK cycle.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RESET  = 2'd1,
        S_ENABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [15:0]           RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0]           TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

    state_t                state;
    state_t                state_nxt;
    logic [15:0]           cnt;
    logic                  set_timeout;
    logic                  set_err;
    logic                  clr_flags;
    logic                  leave_run;
    logic                  arm;
    logic                  wr_en;
    logic [2:0]            ch_q;
    logic [DEPTH_LOG2-1:0] ptr;
    logic [47:0]           sample;
    logic [47:0]           mem [DEPTH];

    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        set_timeout = 1'b0;
        set_err     = 1'b0;
        clr_flags   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_RESET;
                    clr_flags = 1'b1;
                end
            end
            S_RESET: begin
                if (cnt == RST_LAST) state_nxt = S_ENABLE;
            end
            S_ENABLE: begin
                if (valid_i) begin
                    state_nxt = S_RUN;
                end else if (cnt == TO_LAST) begin
                    state_nxt   = S_IDLE;
                    set_timeout = 1'b1;
                end
            end
            S_RUN: begin
                if (!valid_i) begin
                    state_nxt = S_IDLE;
                    set_err   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // stop overrides everything, including a same-cycle start
        if (stop_i) begin
            state_nxt   = S_IDLE;
            set_timeout = 1'b0;
            set_err     = 1'b0;
            clr_flags   = 1'b0;
        end
    end

    // Shared counter: RESET hold length, then low-valid cycles in ENABLE.
    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == S_RESET || (state == S_ENABLE && !valid_i)) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timeout_o <= 1'b0;
            err_o     <= 1'b0;
        end else if (clr_flags) begin
            timeout_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            if (set_timeout) timeout_o <= 1'b1;
            if (set_err)     err_o     <= 1'b1;
        end
    end

    assign leave_run = (state == S_RUN) && (state_nxt != S_RUN);
    assign arm       = capture_i && (state == S_RUN) && !leave_run &&
                       (ch_sel_i <= 3'd5) && !busy_o;
    assign wr_en     = busy_o && valid_i;

    always_comb begin
        sample = '0;
        case (ch_q)
            3'd0:    sample = dat_i[47:0];
            3'd1:    sample = dat_i[95:48];
            3'd2:    sample = dat_i[143:96];
            3'd3:    sample = dat_i[191:144];
            3'd4:    sample = dat_i[239:192];
            3'd5:    sample = dat_i[287:240];
            default: sample = '0;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
            ch_q   <= '0;
            ptr    <= '0;
        end else begin
            if (leave_run) begin
                busy_o <= 1'b0;
            end else if (arm) begin
                busy_o <= 1'b1;
                done_o <= 1'b0;
                ch_q   <= ch_sel_i;
                ptr    <= '0;
            end else if (wr_en) begin
                ptr <= ptr + 1'b1;
                if (ptr == PTR_LAST) begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end
            if (clr_flags) done_o <= 1'b0;
        end
    end

    // Capture RAM has no reset; only the read register is cleared.
    always_ff @(posedge SYSCLK) begin
        if (wr_en) mem[ptr] <= sample;
    end

    always_ff @(posedge SYSCLK or negedge rst_n_i) begin
        if (!rst_n_i) rd_data_o <= '0;
        else          rd_data_o <= mem[rd_addr_i];
    end

    assign fifo_rst_o  = (state == S_RESET);
    assign en_o        = (state == S_ENABLE) || (state == S_RUN);
    assign running_o   = (state == S_RUN);
    assign state_dbg_o = state;

endmodule

// File: tb/tb_glitc_datapath_reader.sv
// Self-checking bench for glitc_datapath_reader: startup, timeout, capture,
// invalid channel, valid drop, stop priority and asynchronous reset.
module tb_glitc_datapath_reader;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int TIMEOUT    = 255;
    localparam int RST_CYCLES = 4;

    logic                  SYSCLK    = 1'b0;
    logic                  rst_n_i   = 1'b0;
    logic                  start_i   = 1'b0;
    logic                  stop_i    = 1'b0;
    logic                  valid_i   = 1'b0;
    logic                  capture_i = 1'b0;
    logic [287:0]          dat_i     = '0;
    logic [2:0]            ch_sel_i  = '0;
    logic [DEPTH_LOG2-1:0] rd_addr_i = '0;
    logic                  fifo_rst_o, en_o, running_o, busy_o, done_o, timeout_o, err_o;
    logic [47:0]           rd_data_o;
    logic [1:0]            state_dbg_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [47:0] exp_mem [DEPTH];
    logic [DEPTH-1:0] mem_known;
    logic [47:0] exp_q[$];

    glitc_datapath_reader #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .TIMEOUT   (TIMEOUT),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .SYSCLK     (SYSCLK),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .fifo_rst_o (fifo_rst_o),
        .en_o       (en_o),
        .valid_i    (valid_i),
        .dat_i      (dat_i),
        .capture_i  (capture_i),
        .ch_sel_i   (ch_sel_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .running_o  (running_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .err_o      (err_o),
        .state_dbg_o(state_dbg_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 SYSCLK = ~SYSCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    function automatic logic [287:0] rand_dat();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [47:0] rand48();
        logic [47:0] v;
        v[47:32] = 16'($urandom);
        v[31:0]  = $urandom;
        return v;
    endfunction

    task automatic bring_up();
        int n;
        stop_i = 1'b1; step(); stop_i = 1'b0;
        valid_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        n = 0;
        while (!en_o && n < 30) begin step(); n++; end
        valid_i = 1'b1;
        step();
        n_checks++;
        if (running_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bring_up: running_o=%b expected 1 (waited %0d)", running_o, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_checks++;
        if ({fifo_rst_o, en_o, running_o, busy_o, done_o, timeout_o, err_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {fifo_rst_o, en_o, running_o, busy_o, done_o, timeout_o, err_o});
        end
        n_checks++;
        if (rd_data_o !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h expected 0", rd_data_o);
        end
        #5 rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_startup();
        valid_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int k = 1; k <= RST_CYCLES; k++) begin
            n_checks++;
            if (fifo_rst_o !== 1'b1 || en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL startup_reset_phase t+%0d: fifo_rst=%b en=%b expected 1 0", k, fifo_rst_o, en_o);
            end
            step();
        end
        n_checks++;
        if (fifo_rst_o !== 1'b0 || en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL startup_enable: fifo_rst=%b en=%b expected 0 1", fifo_rst_o, en_o);
        end
        step(3);
        valid_i = 1'b1;
        n_checks++;
        if (running_o !== 1'b0) begin
            n_fail++;
            $display("FAIL startup_not_running_yet: running=%b expected 0", running_o);
        end
        step();
        n_checks++;
        if (running_o !== 1'b1 || timeout_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL startup_run: running=%b timeout=%b err=%b expected 1 0 0", running_o, timeout_o, err_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        int en_cycles;
        stop_i = 1'b1; step(); stop_i = 1'b0;
        valid_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        n = 0;
        while (fifo_rst_o && n < 20) begin step(); n++; end
        en_cycles = 0;
        while (en_o && en_cycles < 1000) begin en_cycles++; step(); end
        n_checks++;
        if (en_cycles != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_en_cycles: got %0d expected %0d", en_cycles, TIMEOUT);
        end
        n_checks++;
        if (timeout_o !== 1'b1 || en_o !== 1'b0 || running_o !== 1'b0 || fifo_rst_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flag: timeout=%b en=%b running=%b fifo_rst=%b expected 1 0 0 0",
                     timeout_o, en_o, running_o, fifo_rst_o);
        end
        step(3);
        n_checks++;
        if (timeout_o !== 1'b1 || en_o !== 1'b0 || fifo_rst_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle_hold: timeout=%b en=%b fifo_rst=%b expected 1 0 0", timeout_o, en_o, fifo_rst_o);
        end
        start_i = 1'b1; step(); start_i = 1'b0;
        n_checks++;
        if (timeout_o !== 1'b0 || fifo_rst_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_clear_on_start: timeout=%b fifo_rst=%b expected 0 1", timeout_o, fifo_rst_o);
        end
        stop_i = 1'b1; step(); stop_i = 1'b0;
    endtask

    task automatic test_capture(input int ch, input logic [47:0] base, input bit rand_data);
        logic [47:0]  v;
        logic [47:0]  old;
        logic         known;
        logic [287:0] d;
        logic [47:0]  e;
        int           a;
        capture_i = 1'b1; ch_sel_i = 3'(ch); step(); capture_i = 1'b0;
        ch_sel_i = 3'($urandom_range(0, 7));
        n_checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_arm ch%0d: busy=%b done=%b expected 1 0", ch, busy_o, done_o);
        end
        for (int k = 0; k < DEPTH; k++) begin
            v = rand_data ? rand48() : base + 48'(k);
            d = rand_dat();
            d[48*ch +: 48] = v;
            dat_i = d;
            rd_addr_i = 4'(k);
            old = exp_mem[k];
            known = mem_known[k];
            exp_q.push_back(v);
            exp_mem[k] = v;
            mem_known[k] = 1'b1;
            step();
            if (known) begin
                n_checks++;
                if (rd_data_o !== old) begin
                    n_fail++;
                    $display("FAIL read_during_write addr %0d: got %h expected old %h", k, rd_data_o, old);
                end
            end
            if (k < DEPTH - 1) begin
                n_checks++;
                if (busy_o !== 1'b1 || done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL capture_busy write %0d: busy=%b done=%b expected 1 0", k, busy_o, done_o);
                end
            end
        end
        dat_i = rand_dat();
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_done ch%0d: busy=%b done=%b expected 0 1", ch, busy_o, done_o);
        end
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr_i = 4'(k);
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data_o !== e) begin
                n_fail++;
                $display("FAIL readout addr %0d: got %h expected %h", k, rd_data_o, e);
            end
        end
        repeat (6) begin
            a = $urandom_range(0, DEPTH - 1);
            rd_addr_i = 4'(a);
            step();
            n_checks++;
            if (rd_data_o !== exp_mem[a]) begin
                n_fail++;
                $display("FAIL random_read addr %0d: got %h expected %h", a, rd_data_o, exp_mem[a]);
            end
        end
    endtask

    task automatic test_invalid_channel();
        for (int ch = 6; ch <= 7; ch++) begin
            capture_i = 1'b1; ch_sel_i = 3'(ch); dat_i = rand_dat(); step(); capture_i = 1'b0;
            n_checks++;
            if (busy_o !== 1'b0 || done_o !== 1'b1) begin
                n_fail++;
                $display("FAIL invalid_channel %0d: busy=%b done=%b expected 0 1", ch, busy_o, done_o);
            end
        end
        repeat (20) begin dat_i = rand_dat(); step(); end
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr_i = 4'(k);
            step();
            n_checks++;
            if (rd_data_o !== exp_mem[k]) begin
                n_fail++;
                $display("FAIL invalid_channel_ram addr %0d: got %h expected %h", k, rd_data_o, exp_mem[k]);
            end
        end
    endtask

    task automatic test_valid_drop();
        int           ch;
        logic [47:0]  v;
        logic [287:0] d;
        bring_up();
        ch = $urandom_range(0, 5);
        capture_i = 1'b1; ch_sel_i = 3'(ch); step(); capture_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = rand48();
            d = rand_dat();
            d[48*ch +: 48] = v;
            dat_i = d;
            exp_mem[k] = v;
            mem_known[k] = 1'b1;
            step();
        end
        valid_i = 1'b0;
        dat_i = rand_dat();
        step();
        n_checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || en_o !== 1'b0 || running_o !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop: err=%b busy=%b done=%b en=%b running=%b expected 1 0 0 0 0",
                     err_o, busy_o, done_o, en_o, running_o);
        end
        for (int k = 0; k < 5; k++) begin
            rd_addr_i = 4'(k);
            step();
            n_checks++;
            if (rd_data_o !== exp_mem[k]) begin
                n_fail++;
                $display("FAIL valid_drop_partial addr %0d: got %h expected %h", k, rd_data_o, exp_mem[k]);
            end
        end
    endtask

    task automatic test_priority();
        int           ch;
        logic [47:0]  v;
        logic [287:0] d;
        stop_i = 1'b1; step(); stop_i = 1'b0;
        valid_i = 1'b0;
        start_i = 1'b1; stop_i = 1'b1; step(); start_i = 1'b0; stop_i = 1'b0;
        n_checks++;
        if (fifo_rst_o !== 1'b0 || en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same_cycle: fifo_rst=%b en=%b expected 0 0", fifo_rst_o, en_o);
        end
        step(3);
        n_checks++;
        if (fifo_rst_o !== 1'b0 || en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_idle_hold: fifo_rst=%b en=%b expected 0 0", fifo_rst_o, en_o);
        end
        capture_i = 1'b1; ch_sel_i = 3'd2; step(); capture_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_outside_run: busy=%b expected 0", busy_o);
        end
        bring_up();
        start_i = 1'b1; step(); start_i = 1'b0;
        n_checks++;
        if (fifo_rst_o !== 1'b0 || running_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored_in_run: fifo_rst=%b running=%b expected 0 1", fifo_rst_o, running_o);
        end
        ch = $urandom_range(0, 5);
        capture_i = 1'b1; ch_sel_i = 3'(ch); step(); capture_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v = rand48();
            d = rand_dat();
            d[48*ch +: 48] = v;
            dat_i = d;
            exp_mem[k] = v;
            mem_known[k] = 1'b1;
            step();
        end
        mem_known[3] = 1'b0;
        dat_i = rand_dat();
        stop_i = 1'b1; step(); stop_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || en_o !== 1'b0 || running_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_mid_capture: busy=%b done=%b en=%b running=%b err=%b expected 0 0 0 0 0",
                     busy_o, done_o, en_o, running_o, err_o);
        end
    endtask

    task automatic test_async_reset();
        int ch;
        bring_up();
        ch = $urandom_range(0, 5);
        capture_i = 1'b1; ch_sel_i = 3'(ch); step(); capture_i = 1'b0;
        dat_i = rand_dat();
        step(2);
        rd_addr_i = 4'd0;
        n_checks++;
        if (busy_o !== 1'b1 || running_o !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_precondition: busy=%b running=%b expected 1 1", busy_o, running_o);
        end
        #3 rst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({fifo_rst_o, en_o, running_o, busy_o, done_o, timeout_o, err_o} !== 7'b0 || rd_data_o !== 48'h0) begin
            n_fail++;
            $display("FAIL async_reset: flags=%b rd_data=%h expected 0000000 0",
                     {fifo_rst_o, en_o, running_o, busy_o, done_o, timeout_o, err_o}, rd_data_o);
        end
        mem_known = '0;
        #2 rst_n_i = 1'b1;
        valid_i = 1'b0;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        mem_known = '0;
        test_reset();
        test_startup();
        test_timeout();
        bring_up();
        test_capture(3, 48'h0000_0000_0100, 1'b0);
        test_invalid_channel();
        test_capture($urandom_range(0, 5), 48'h0, 1'b1);
        test_capture($urandom_range(0, 5), 48'h0, 1'b1);
        test_valid_drop();
        test_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
